mem_ctrl_param: RTL and testbench
=================================

# mem_ctrl_param

Parametrised single-port, byte-addressed memory block with a valid/ready request/response handshake. It supports byte, halfword and word accesses with little-endian byte lanes. A configurable base address, a write-protected ROM region and an optional clear-on-reset sequencer are built in. It sits between the core's load/store/fetch path and on-chip RAM, replacing the fixed-size, combinational-read memory.

## Interface
- DEPTH, 16384: memory depth in 32-bit words (≥ 4, power of two); capacity is DEPTH*4 bytes.
- ADDR_BASE, 32'h00000000: byte address of word 0 (DEPTH*4-aligned).
- ROM_WORDS, 0: words 0..ROM_WORDS-1 are write-protected (0 = none).
- CLEAR_ON_RESET, 1: 1 = zero the whole array after every reset; 0 = contents survive reset.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_wdata  in  32  write data, right-aligned (bits [7:0] for byte).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  read data, right-aligned, zero-extended; 0 for writes and errors.
- rsp_err  out  1  request rejected (see Operation).
- init_done  out  1  1 once the clear sequence has finished.

## Operation
- The FSM has three states: CLEAR, IDLE and RESP.
- Reset (rst low) values:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - clear counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - init_done = !CLEAR_ON_RESET.
  - req_ready = 0.
- The memory array is never touched by the asynchronous reset. It is written only by the clear sequencer or by accepted writes, so that it stays RAM-inferable.
- CLEAR state:
  - Each cycle writes 32'h0 to word clr_cnt and increments clr_cnt.
  - After word DEPTH-1 is written: init_done = 1 and state goes to IDLE.
  - req_ready = 0 throughout.
- IDLE state:
  - req_ready = 1 (decoded as state == IDLE).
  - A request is accepted on an edge where req_valid & req_ready.
  - off = req_addr - ADDR_BASE (32-bit wrap); word index = off[.. :2].
- An error is flagged (rsp_err = 1) if any of the following holds:
  - off >= DEPTH*4;
  - req_size == 3;
  - halfword with req_addr[0] = 1;
  - word with req_addr[1:0] != 0;
  - write with word index < ROM_WORDS.
- On error, no array write occurs and rsp_rdata = 0.
- Write:
  - Byte lanes are enabled by size and addr[1:0]: byte → lane addr[1:0]; half → lanes addr[1]*2 and +1; word → all lanes.
  - Lane k receives req_wdata shifted left by 8*addr[1:0].
  - rsp_rdata = 0.
- Read:
  - rsp_rdata = (word >> 8*addr[1:0]), masked to 8/16/32 bits.
  - Byte 0 of the word is bits [7:0] (little-endian).
- After acceptance, state goes to RESP with rsp_valid = 1; rsp_rdata and rsp_err are registered.
- RESP state:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is sampled high.
  - Then rsp_valid = 0 and state goes to IDLE.
  - req_ready = 0, so a new req_valid is ignored and not queued.
- Reset mid-operation:
  - Any response is discarded immediately (async).
  - A write accepted before reset has already been committed.
  - A clear sequence in progress restarts from word 0.

## Timing
- Accept edge N → rsp_valid high after edge N (1-cycle latency).
- If rsp_ready is high in that cycle: handshake at edge N+1, req_ready high after N+1.
- Peak throughput is one access per 2 cycles.
- The write is visible to a read accepted at edge N+2 or later.
- Clear takes exactly DEPTH cycles after reset release: init_done rises after the DEPTH-th edge.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to rsp_*.

## Test plan
- Clear sequence, DEPTH=16, CLEAR_ON_RESET=1:
  - req_ready = 0 and init_done = 0 for 16 cycles after rst rises; init_done = 1 on cycle 17.
  - A word read of 0x3C then returns 0x00000000 with err 0.
- Lanes, DEPTH≥64:
  - Word write 0x98BADCFF to 0xF8.
  - Read byte at 0xF9 → 0x000000DC; half at 0xFA → 0x000098BA; word at 0xF8 → 0x98BADCFF.
- Partial write: byte write 0x55 to 0xF9, then word read of 0xF8 → 0x98BA55FF. Half write 0x1234 to 0xF8 → 0x98BA1234.
- Errors:
  - Word read at 0x2 → err 1, rdata 0.
  - With ROM_WORDS=4, word write to 0x8 → err 1; a subsequent read of 0x8 is unchanged.
  - Read at ADDR_BASE+DEPTH*4 → err 1.
  - req_size=3 → err 1.
- Backpressure: hold rsp_ready low for 5 cycles with req_valid high.
  - rsp_valid/rsp_rdata stay stable and req_ready stays 0.
  - The second request is accepted only after the response handshake.
- Reset during RESP: drop rst low while in RESP.
  - rsp_valid = 0 immediately.
  - After release, the CLEAR sequence reruns; with CLEAR_ON_RESET=0, a prior write still reads back.

Source files
------------

// File: rtl/mem_ctrl_param_if.sv
// Request/response bus between a load/store/fetch client and mem_ctrl_param.
interface mem_ctrl_param_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_ctrl_param.sv
// Single-port byte-addressed memory with valid/ready request/response handshake,
// byte/half/word little-endian lanes, base offset, write-protected ROM window and
// an optional clear-after-reset sequencer.
module mem_ctrl_param #(
  parameter int unsigned DEPTH          = 16384,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned ROM_WORDS      = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mem_ctrl_param_if.slave        io_bus,
  output logic                   o_init_done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StClear, StIdle, StResp} state_e;

  localparam state_e RstState = CLEAR_ON_RESET ? StClear : StIdle;

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_clr_cnt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic          r_init_done;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [4:0]    w_sh;
  logic          w_accept;
  logic          w_oor;
  logic          w_bad_fmt;
  logic          w_rom_hit;
  logic          w_err;
  logic          w_wr_en;
  logic          w_clr_we;
  logic          w_clr_last;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_sh;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_rd_shift;
  logic [31:0]   w_rd_data;

  // Address decode relative to the configured base (32-bit wrap makes below-base
  // addresses look huge, so they fall out of range as well).
  assign w_off      = io_bus.req_addr - ADDR_BASE;
  assign w_idx      = w_off[AW+1:2];
  assign w_sh       = {io_bus.req_addr[1:0], 3'b000};
  assign w_oor      = (w_off >= (32'(DEPTH) << 2));
  assign w_accept   = io_bus.req_valid & r_req_ready;
  assign w_clr_we   = (r_state == StClear);
  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  if (ROM_WORDS > 0) begin : g_rom
    assign w_rom_hit = ({2'b00, w_off[31:2]} < 32'(ROM_WORDS));
  end else begin : g_no_rom
    assign w_rom_hit = 1'b0;
  end

  // Lane enables and alignment check from size and low address bits.
  always_comb begin
    w_be      = 4'b0000;
    w_bad_fmt = 1'b0;
    case (io_bus.req_size)
      2'd0: w_be = 4'b0001 << io_bus.req_addr[1:0];
      2'd1: begin
        w_be      = io_bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_bad_fmt = io_bus.req_addr[0];
      end
      2'd2: begin
        w_be      = 4'b1111;
        w_bad_fmt = |io_bus.req_addr[1:0];
      end
      default: w_bad_fmt = 1'b1;
    endcase
  end

  assign w_err      = w_oor | w_bad_fmt | (io_bus.req_write & w_rom_hit);
  assign w_wr_en    = w_accept & io_bus.req_write & ~w_err;
  assign w_wdata_sh = io_bus.req_wdata << w_sh;
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> w_sh;

  // Right-align and zero-extend read data to the access size.
  always_comb begin
    w_rd_data = w_rd_shift;
    case (io_bus.req_size)
      2'd0:    w_rd_data = {24'h0, w_rd_shift[7:0]};
      2'd1:    w_rd_data = {16'h0, w_rd_shift[15:0]};
      default: w_rd_data = w_rd_shift;
    endcase
  end

  // Array write port: clear sequencer or accepted byte-enabled write; no reset so it
  // stays RAM-inferable.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= 32'h0;
    end else if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata_sh[8*k +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StClear: if (w_clr_last) w_state_d = StIdle;
      StIdle:  if (w_accept) w_state_d = StResp;
      StResp:  if (io_bus.rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RstState;
    else          r_state <= w_state_d;
  end

  // Clear counter, registered response and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_init_done <= !CLEAR_ON_RESET;
    end else begin
      // Registered copy of "next state is IDLE" keeps req_ready low in reset.
      r_req_ready <= (w_state_d == StIdle);
      if (r_state == StClear) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (w_clr_last) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || io_bus.req_write) ? 32'h0 : w_rd_data;
      end else if ((r_state == StResp) && io_bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;
  assign o_init_done      = r_init_done;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Directed bench for mem_ctrl_param: instance A (DEPTH 64, ROM 4 words, clear on
// reset, base 0) and instance B (DEPTH 16, no clear, base 0x2000).
module tb_mem_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        t_valid, t_write, t_rready;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  logic        a_init, b_init;

  mem_ctrl_param_if a_if ();
  mem_ctrl_param_if b_if ();

  assign a_if.req_valid = t_valid & ~sel;
  assign b_if.req_valid = t_valid & sel;
  assign a_if.rsp_ready = t_rready & ~sel;
  assign b_if.rsp_ready = t_rready & sel;
  assign a_if.req_write = t_write;
  assign b_if.req_write = t_write;
  assign a_if.req_size  = t_size;
  assign b_if.req_size  = t_size;
  assign a_if.req_addr  = t_addr;
  assign b_if.req_addr  = t_addr;
  assign a_if.req_wdata = t_wdata;
  assign b_if.req_wdata = t_wdata;

  logic        s_req_ready, s_rsp_valid, s_err;
  logic [31:0] s_rdata;
  assign s_req_ready = sel ? b_if.req_ready : a_if.req_ready;
  assign s_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
  assign s_err       = sel ? b_if.rsp_err   : a_if.rsp_err;
  assign s_rdata     = sel ? b_if.rsp_rdata : a_if.rsp_rdata;

  mem_ctrl_param #(
    .DEPTH(64), .ADDR_BASE(32'h0000_0000), .ROM_WORDS(4), .CLEAR_ON_RESET(1'b1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .io_bus(a_if), .o_init_done(a_init)
  );

  mem_ctrl_param #(
    .DEPTH(16), .ADDR_BASE(32'h0000_2000), .ROM_WORDS(0), .CLEAR_ON_RESET(1'b0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .io_bus(b_if), .o_init_done(b_init)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready high; returns the response.
  task automatic xact(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    t_valid = 1'b1; t_write = wr; t_size = sz; t_addr = addr; t_wdata = wd;
    t_rready = 1'b1;
    n = 0;
    while (s_req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("req_ready_timeout", 32'(s_req_ready), 32'd1);
    @(negedge clk);
    t_valid = 1'b0;
    n = 0;
    while (s_rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rsp_valid_timeout", 32'(s_rsp_valid), 32'd1);
    rd = s_rdata;
    er = s_err;
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] sz,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    xact(wr, sz, addr, wd, rd, er);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  // Counts edges after reset release; init_done and req_ready must rise only after edge 64.
  task automatic clear_window(input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (a_init !== 1'(i == 64) || a_if.req_ready !== 1'(i == 64)) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    t_valid = 1'b0; t_write = 1'b0; t_size = 2'd2; t_addr = 32'h0; t_wdata = 32'h0;
    t_rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("a_rst_req_ready", 32'(a_if.req_ready), 32'd0);
    chk("a_rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    chk("a_rst_init_done", 32'(a_init), 32'd0);
    chk("b_rst_req_ready", 32'(b_if.req_ready), 32'd0);
    chk("b_rst_init_done", 32'(b_init), 32'd1);

    rst_a = 1'b1; rst_b = 1'b1;
    clear_window("a_clear_timing");
    op("a_read_cleared", 1'b0, 2'd2, 32'h3C, 32'h0, 32'h0, 1'b0);

    // Lanes
    op("a_wr_word_f8", 1'b1, 2'd2, 32'hF8, 32'h98BADCFF, 32'h0, 1'b0);
    op("a_rd_byte_f9", 1'b0, 2'd0, 32'hF9, 32'h0, 32'h0000_00DC, 1'b0);
    op("a_rd_half_fa", 1'b0, 2'd1, 32'hFA, 32'h0, 32'h0000_98BA, 1'b0);
    op("a_rd_word_f8", 1'b0, 2'd2, 32'hF8, 32'h0, 32'h98BADCFF, 1'b0);
    op("a_rd_byte_fb", 1'b0, 2'd0, 32'hFB, 32'h0, 32'h0000_0098, 1'b0);

    // Partial writes (upper wdata bits must be ignored)
    op("a_wr_byte_f9", 1'b1, 2'd0, 32'hF9, 32'hAAAAAA55, 32'h0, 1'b0);
    op("a_rd_after_b", 1'b0, 2'd2, 32'hF8, 32'h0, 32'h98BA55FF, 1'b0);
    op("a_wr_half_f8", 1'b1, 2'd1, 32'hF8, 32'hEEEE1234, 32'h0, 1'b0);
    op("a_rd_after_h", 1'b0, 2'd2, 32'hF8, 32'h0, 32'h98BA1234, 1'b0);

    // Errors
    op("a_mis_word", 1'b0, 2'd2, 32'h2, 32'h0, 32'h0, 1'b1);
    op("a_mis_half", 1'b0, 2'd1, 32'hF9, 32'h0, 32'h0, 1'b1);
    op("a_rom_write", 1'b1, 2'd2, 32'h8, 32'hDEADBEEF, 32'h0, 1'b1);
    op("a_rom_read", 1'b0, 2'd2, 32'h8, 32'h0, 32'h0, 1'b0);
    op("a_wr_word4", 1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
    op("a_rd_word4", 1'b0, 2'd2, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
    op("a_oor", 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    op("a_size3", 1'b0, 2'd3, 32'h20, 32'h0, 32'h0, 1'b1);
    op("a_wr_40", 1'b1, 2'd2, 32'h40, 32'h11223344, 32'h0, 1'b0);

    // Backpressure: response held for 5 cycles while a second request waits
    @(negedge clk);
    t_valid = 1'b1; t_write = 1'b0; t_size = 2'd2; t_addr = 32'h40; t_rready = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_rsp_valid !== 1'b1 || s_rdata !== 32'h11223344 || s_req_ready !== 1'b0) bad++;
      t_addr = 32'h10;
      @(negedge clk);
    end
    chk("bp_hold_stable", 32'(bad), 32'd0);
    t_rready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_dropped", 32'(s_rsp_valid), 32'd0);
    chk("bp_req_ready", 32'(s_req_ready), 32'd1);
    @(negedge clk);
    chk("bp_second_valid", 32'(s_rsp_valid), 32'd1);
    chk("bp_second_rdata", s_rdata, 32'hCAFEF00D);
    t_valid = 1'b0;

    // Reset during RESP on A: response vanishes, clear reruns
    @(negedge clk);
    t_valid = 1'b1; t_write = 1'b0; t_size = 2'd2; t_addr = 32'hF8; t_rready = 1'b0;
    @(negedge clk);
    t_valid = 1'b0;
    chk("a_resp_before_rst", 32'(s_rsp_valid), 32'd1);
    #2 rst_a = 1'b0;
    #1 chk("a_rst_async_valid", 32'(s_rsp_valid), 32'd0);
    @(negedge clk);
    chk("a_rst_init_low", 32'(a_init), 32'd0);
    rst_a = 1'b1;
    clear_window("a_reclear_timing");
    op("a_rd_after_clr", 1'b0, 2'd2, 32'hF8, 32'h0, 32'h0, 1'b0);

    // Instance B: base offset, range, retention across reset
    sel = 1'b1;
    op("b_wr_2004", 1'b1, 2'd2, 32'h2004, 32'hA5A55A5A, 32'h0, 1'b0);
    op("b_rd_2004", 1'b0, 2'd2, 32'h2004, 32'h0, 32'hA5A55A5A, 1'b0);
    op("b_rd_byte_2007", 1'b0, 2'd0, 32'h2007, 32'h0, 32'h0000_00A5, 1'b0);
    op("b_oor_top", 1'b0, 2'd2, 32'h2040, 32'h0, 32'h0, 1'b1);
    op("b_oor_below", 1'b0, 2'd2, 32'h1FFC, 32'h0, 32'h0, 1'b1);

    @(negedge clk);
    t_valid = 1'b1; t_write = 1'b0; t_size = 2'd2; t_addr = 32'h2004; t_rready = 1'b0;
    @(negedge clk);
    t_valid = 1'b0;
    chk("b_resp_before_rst", 32'(s_rsp_valid), 32'd1);
    #2 rst_b = 1'b0;
    #1 chk("b_rst_async_valid", 32'(s_rsp_valid), 32'd0);
    chk("b_rst_init_high", 32'(b_init), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    op("b_retained", 1'b0, 2'd2, 32'h2004, 32'h0, 32'hA5A55A5A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
